// File: rtl/iq_sample_packer_pkg.sv
// Shared types and elaboration-time helpers for the IQ sample packer.
package iq_pack_pkg;

   // One input sample as it arrives on the stream: I in the top half, Q in the bottom half.
   typedef struct packed {
      logic [15:0] i;
      logic [15:0] q;
   } iq_sample_t;

   // Number of requantised samples that fit in one output word.
   function automatic int calc_pack(input int out_width, input int samp_bits);
      return out_width / (2 * samp_bits);
   endfunction

   // Lane counter width; a single-lane word still needs a 1-bit counter.
   function automatic int calc_cnt_w(input int pack);
      return (pack > 1) ? $clog2(pack) : 1;
   endfunction

   // Width of the valid-sample count carried on o_tuser (1..PACK).
   function automatic int calc_user_w(input int pack);
      return $clog2(pack + 1);
   endfunction

   // Bit position of lane k's LSB inside the output word.
   function automatic int lane_lsb(input int k, input bit msb_first, input int samp_bits,
                                   input int out_width);
      return msb_first ? (out_width - (k + 1) * 2 * samp_bits) : (k * 2 * samp_bits);
   endfunction

   // Constants for the default configuration (4+4-bit samples into 32-bit words).
   localparam int DEF_SAMP_BITS = 4;
   localparam int DEF_OUT_WIDTH = 32;
   localparam int PACK          = calc_pack(DEF_OUT_WIDTH, DEF_SAMP_BITS);
   localparam int CNT_W         = calc_cnt_w(PACK);

endpackage

// File: rtl/iq_sample_packer_if.sv
// Stream bundle for the packer: 32-bit sample input side and packed-word output side.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready are both 1;
// a source holding tvalid=1 keeps its payload stable until that transfer happens.
interface iq_sample_packer_if #(
   parameter int OUT_WIDTH = 32,
   parameter int USER_W    = 3
);
   logic [31:0]          i_tdata;
   logic                 i_tlast;
   logic                 i_tvalid;
   logic                 i_tready;
   logic [OUT_WIDTH-1:0] o_tdata;
   logic [USER_W-1:0]    o_tuser;
   logic                 o_tlast;
   logic                 o_tvalid;
   logic                 o_tready;

   // Packer side: consumes samples, produces packed words.
   modport slave (
      input  i_tdata, i_tlast, i_tvalid,
      output i_tready,
      output o_tdata, o_tuser, o_tlast, o_tvalid,
      input  o_tready
   );

   // Environment side: supplies samples, consumes packed words.
   modport master (
      output i_tdata, i_tlast, i_tvalid,
      input  i_tready,
      input  o_tdata, o_tuser, o_tlast, o_tvalid,
      output o_tready
   );
endinterface

// File: rtl/iq_sample_packer_quant.sv
// Combinational requantiser for one 16-bit two's-complement component: keeps the top
// SAMP_BITS, optionally rounds half up, and clamps at the positive maximum.
module iq_component_quant #(
   parameter int SAMP_BITS = 4,
   parameter int ROUND_EN  = 1
) (
   input  logic [15:0]          i_x,
   output logic [SAMP_BITS-1:0] o_q,
   output logic                 o_sat
);
   // Largest positive value representable in SAMP_BITS, i.e. {0,1..1}.
   localparam logic [SAMP_BITS-1:0] MAX_POS = SAMP_BITS'((2 ** (SAMP_BITS - 1)) - 1);
   // Bit just below the kept field; clamped so a full-width config still elaborates.
   localparam int HALF_IDX = (SAMP_BITS < 16) ? (15 - SAMP_BITS) : 0;

   logic [SAMP_BITS-1:0] w_trunc;
   logic                 w_unused;

   assign w_trunc  = i_x[15 -: SAMP_BITS];
   assign w_unused = ^i_x;

   if ((ROUND_EN != 0) && (SAMP_BITS < 16)) begin : g_round
      // Round half up; only the positive maximum can overflow, so it is held there instead.
      always_comb begin
         o_q   = w_trunc;
         o_sat = 1'b0;
         if (i_x[HALF_IDX]) begin
            if (w_trunc == MAX_POS) begin
               o_sat = 1'b1;
            end else begin
               o_q = w_trunc + SAMP_BITS'(1);
            end
         end
      end
   end else begin : g_trunc
      // Plain truncation to the MSBs never saturates.
      always_comb begin
         o_q   = w_trunc;
         o_sat = 1'b0;
      end
   end
endmodule

// File: rtl/iq_sample_packer.sv
// Requantises 16+16-bit IQ samples and packs PACK of them per output word.
// Stage 1 is a lane accumulator, stage 2 the output register; a partial word is
// flushed with zero-filled lanes when the input marks the end of a packet.
module iq_sample_packer
   import iq_pack_pkg::*;
#(
   parameter int SAMP_BITS = 4,
   parameter int OUT_WIDTH = 32,
   parameter int ROUND_EN  = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic                clk,
   input  logic                reset,
   iq_sample_packer_if.slave   s_if,
   output logic [15:0]         sat_count
);
   localparam int LANE_W = 2 * SAMP_BITS;
   localparam int NLANES = calc_pack(OUT_WIDTH, SAMP_BITS);
   localparam int CNT_LW = calc_cnt_w(NLANES);
   localparam int USER_W = calc_user_w(NLANES);

   iq_sample_t           w_in;
   logic [SAMP_BITS-1:0] w_i_q;
   logic [SAMP_BITS-1:0] w_q_q;
   logic                 w_i_sat;
   logic                 w_q_sat;
   logic [LANE_W-1:0]    w_lane;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_done;
   logic [OUT_WIDTH-1:0] w_merged;

   logic [OUT_WIDTH-1:0] r_acc;
   logic [CNT_LW-1:0]    r_cnt;
   logic [OUT_WIDTH-1:0] r_o_tdata;
   logic [USER_W-1:0]    r_o_tuser;
   logic                 r_o_tlast;
   logic                 r_o_tvalid;
   logic [15:0]          r_sat_count;

   assign w_in = s_if.i_tdata;

   iq_component_quant #(.SAMP_BITS(SAMP_BITS), .ROUND_EN(ROUND_EN)) u_quant_i (
      .i_x   (w_in.i),
      .o_q   (w_i_q),
      .o_sat (w_i_sat)
   );

   iq_component_quant #(.SAMP_BITS(SAMP_BITS), .ROUND_EN(ROUND_EN)) u_quant_q (
      .i_x   (w_in.q),
      .o_q   (w_q_q),
      .o_sat (w_q_sat)
   );

   assign w_lane   = {w_i_q, w_q_q};
   // Accept whenever the output register is empty or being drained this cycle.
   assign w_ready  = ~r_o_tvalid | s_if.o_tready;
   assign w_accept = s_if.i_tvalid & w_ready;
   assign w_done   = (r_cnt == CNT_LW'(NLANES - 1)) | s_if.i_tlast;

   // Drop the incoming lane into the slot selected by the lane counter.
   always_comb begin
      w_merged = r_acc;
      for (int k = 0; k < NLANES; k++) begin
         if (r_cnt == CNT_LW'(k)) begin
            w_merged[lane_lsb(k, (MSB_FIRST != 0), SAMP_BITS, OUT_WIDTH) +: LANE_W] = w_lane;
         end
      end
   end

   // Accumulator and lane counter: restart at lane 0 after every completed word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         if (w_done) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else begin
            r_acc <= w_merged;
            r_cnt <= r_cnt + CNT_LW'(1);
         end
      end
   end

   // Output register: load a finished word, otherwise clear valid once the beat is taken.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_o_tdata  <= '0;
         r_o_tuser  <= '0;
         r_o_tlast  <= 1'b0;
         r_o_tvalid <= 1'b0;
      end else if (w_accept && w_done) begin
         r_o_tdata  <= w_merged;
         r_o_tuser  <= USER_W'(r_cnt) + USER_W'(1);
         r_o_tlast  <= s_if.i_tlast;
         r_o_tvalid <= 1'b1;
      end else if (s_if.o_tready) begin
         r_o_tvalid <= 1'b0;
      end
   end

   // Saturation counter: one count per accepted sample with either component clamped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sat_count <= '0;
      end else if (w_accept && (w_i_sat || w_q_sat) && (r_sat_count != 16'hFFFF)) begin
         r_sat_count <= r_sat_count + 16'd1;
      end
   end

   assign s_if.i_tready = w_ready;
   assign s_if.o_tdata  = r_o_tdata;
   assign s_if.o_tuser  = r_o_tuser;
   assign s_if.o_tlast  = r_o_tlast;
   assign s_if.o_tvalid = r_o_tvalid;
   assign sat_count     = r_sat_count;
endmodule

// File: tb/tb_iq_sample_packer.sv
// Bench for iq_sample_packer: three instances (round+MSB-first, truncate+MSB-first,
// round+LSB-first) share one input stream and one o_tready, so they stay in lockstep.
module tb_iq_sample_packer;
   typedef struct packed {
      logic [31:0] d;
      logic [2:0]  u;
      logic        l;
   } beat_t;

   typedef struct {
      logic [31:0] s[4];
      int          n;
      logic        last;
      logic [31:0] exp_d[3];
      logic [2:0]  exp_u;
      logic        exp_l;
      logic [15:0] exp_sat;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        o_tready = 1'b1;
   logic [31:0] in_d = '0;
   logic        in_l = 1'b0;
   logic        in_v = 1'b0;
   logic [15:0] sat_a, sat_b, sat_c;

   int          checks = 0;
   int          errors = 0;
   beat_t       exp_q[3][$];
   logic [31:0] pend[4];
   int          pend_n = 0;
   int          exp_sat = 0;
   int          n_acc = 0;
   bit          rand_done = 0;
   vec_t        vt[4];

   logic [31:0] mon_d[3];
   logic [2:0]  mon_u[3];
   logic        mon_l[3];
   logic        mon_v[3];
   logic [15:0] mon_sat[3];

   iq_sample_packer_if #(.OUT_WIDTH(32), .USER_W(3)) if_a ();
   iq_sample_packer_if #(.OUT_WIDTH(32), .USER_W(3)) if_b ();
   iq_sample_packer_if #(.OUT_WIDTH(32), .USER_W(3)) if_c ();

   iq_sample_packer #(.SAMP_BITS(4), .OUT_WIDTH(32), .ROUND_EN(1), .MSB_FIRST(1)) u_a (
      .clk(clk), .reset(reset), .s_if(if_a.slave), .sat_count(sat_a));
   iq_sample_packer #(.SAMP_BITS(4), .OUT_WIDTH(32), .ROUND_EN(0), .MSB_FIRST(1)) u_b (
      .clk(clk), .reset(reset), .s_if(if_b.slave), .sat_count(sat_b));
   iq_sample_packer #(.SAMP_BITS(4), .OUT_WIDTH(32), .ROUND_EN(1), .MSB_FIRST(0)) u_c (
      .clk(clk), .reset(reset), .s_if(if_c.slave), .sat_count(sat_c));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- shared stimulus wiring ----------------
   assign if_a.i_tdata = in_d;  assign if_a.i_tlast = in_l;  assign if_a.i_tvalid = in_v;
   assign if_b.i_tdata = in_d;  assign if_b.i_tlast = in_l;  assign if_b.i_tvalid = in_v;
   assign if_c.i_tdata = in_d;  assign if_c.i_tlast = in_l;  assign if_c.i_tvalid = in_v;
   assign if_a.o_tready = o_tready;
   assign if_b.o_tready = o_tready;
   assign if_c.o_tready = o_tready;

   assign mon_d[0] = if_a.o_tdata;  assign mon_d[1] = if_b.o_tdata;  assign mon_d[2] = if_c.o_tdata;
   assign mon_u[0] = if_a.o_tuser;  assign mon_u[1] = if_b.o_tuser;  assign mon_u[2] = if_c.o_tuser;
   assign mon_l[0] = if_a.o_tlast;  assign mon_l[1] = if_b.o_tlast;  assign mon_l[2] = if_c.o_tlast;
   assign mon_v[0] = if_a.o_tvalid; assign mon_v[1] = if_b.o_tvalid; assign mon_v[2] = if_c.o_tvalid;
   assign mon_sat[0] = sat_a;       assign mon_sat[1] = sat_b;       assign mon_sat[2] = sat_c;

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, got, want, $time);
      end
   endtask

   // Reference quantiser: value / 2^12, optionally +0.5, floored, clamped at +7.
   function automatic logic [3:0] qref(input logic [15:0] x, input bit rnd, output bit sat);
      int v;
      v = int'($signed(x));
      if (rnd) v = v + 2048;
      v = v >>> 12;
      sat = 1'b0;
      if (v > 7) begin
         v   = 7;
         sat = 1'b1;
      end
      return v[3:0];
   endfunction

   // Packs the pending samples for variant v (0: round/MSB, 1: trunc/MSB, 2: round/LSB).
   function automatic logic [31:0] build(input int v);
      logic [31:0] w;
      logic [7:0]  lane;
      bit          rnd, msb, s;
      int          pos;
      rnd = (v != 1);
      msb = (v != 2);
      w   = '0;
      for (int k = 0; k < pend_n; k++) begin
         lane = {qref(pend[k][31:16], rnd, s), qref(pend[k][15:0], rnd, s)};
         pos  = msb ? (24 - 8 * k) : (8 * k);
         w    = w | (32'(lane) << pos);
      end
      return w;
   endfunction

   task automatic model_push(input logic [31:0] d, input logic l);
      bit          si, sq;
      logic [3:0]  t;
      beat_t       b;
      pend[pend_n] = d;
      pend_n++;
      t = qref(d[31:16], 1'b1, si);
      t = qref(d[15:0], 1'b1, sq);
      if ((si || sq) && exp_sat < 65535) exp_sat++;
      if (pend_n == 4 || l) begin
         for (int v = 0; v < 3; v++) begin
            b.d = build(v);
            b.u = 3'(pend_n);
            b.l = l;
            exp_q[v].push_back(b);
         end
         pend_n = 0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Called at negedge+1; ready is sampled just before the rising edge.
   task automatic send(input logic [31:0] d, input logic l);
      bit ok;
      ok   = 1'b0;
      in_d = d;
      in_l = l;
      in_v = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         #3;
         ok = if_a.i_tready;
         @(negedge clk);
         #1;
      end
      chk("send_accept", 32'(ok), 32'd1);
      if (ok) begin
         model_push(d, l);
         n_acc++;
      end else begin
         in_v = 1'b0;
      end
   endtask

   task automatic idle();
      in_v = 1'b0;
      in_l = 1'b0;
   endtask

   task automatic wait_valid();
      for (int c = 0; c < 20 && !mon_v[0]; c++) tick();
      chk("wait_valid", 32'(mon_v[0]), 32'd1);
   endtask

   task automatic drain();
      for (int c = 0; c < 200 && exp_q[0].size() != 0; c++) tick();
      for (int v = 0; v < 3; v++) chk($sformatf("drain_q%0d", v), exp_q[v].size(), 0);
   endtask

   function automatic logic [15:0] rnd_comp();
      case ($urandom_range(0, 3))
         0:       return 16'h7800 + 16'($urandom_range(0, 16'h07FF));
         1:       return 16'hF800 + 16'($urandom_range(0, 16'h07FF));
         default: return 16'($urandom);
      endcase
   endfunction

   // ---------------- scoreboard: check each output beat just before its edge ----------------
   always begin
      @(negedge clk);
      #4;
      if (reset && o_tready) begin
         for (int v = 0; v < 3; v++) begin
            if (mon_v[v]) begin
               if (exp_q[v].size() == 0) begin
                  chk($sformatf("beat%0d_unexpected", v), 32'(mon_v[v]), 32'd0);
               end else begin
                  beat_t e;
                  e = exp_q[v].pop_front();
                  chk($sformatf("beat%0d_data", v), mon_d[v], e.d);
                  chk($sformatf("beat%0d_user", v), 32'(mon_u[v]), 32'(e.u));
                  chk($sformatf("beat%0d_last", v), 32'(mon_l[v]), 32'(e.l));
               end
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      // Directed vectors: I/Q in hex, expected words for the three variants.
      vt[0].s[0] = 32'h12345678; vt[0].s[1] = 32'h9ABCDEF0;
      vt[0].s[2] = 32'h7FFF8000; vt[0].s[3] = 32'h0000FFFF;
      vt[0].n = 4; vt[0].last = 1'b0;
      vt[0].exp_d[0] = 32'h15AE7800; vt[0].exp_d[1] = 32'h159D780F; vt[0].exp_d[2] = 32'h0078AE15;
      vt[0].exp_u = 3'd4; vt[0].exp_l = 1'b0; vt[0].exp_sat = 16'd1;

      vt[1].s[0] = 32'h12345678; vt[1].s[1] = 32'h9ABCDEF0; vt[1].s[2] = '0; vt[1].s[3] = '0;
      vt[1].n = 2; vt[1].last = 1'b1;
      vt[1].exp_d[0] = 32'h15AE0000; vt[1].exp_d[1] = 32'h159D0000; vt[1].exp_d[2] = 32'h0000AE15;
      vt[1].exp_u = 3'd2; vt[1].exp_l = 1'b1; vt[1].exp_sat = 16'd1;

      vt[2].s[0] = 32'h7FFF8000; vt[2].s[1] = '0; vt[2].s[2] = '0; vt[2].s[3] = '0;
      vt[2].n = 1; vt[2].last = 1'b1;
      vt[2].exp_d[0] = 32'h78000000; vt[2].exp_d[1] = 32'h78000000; vt[2].exp_d[2] = 32'h00000078;
      vt[2].exp_u = 3'd1; vt[2].exp_l = 1'b1; vt[2].exp_sat = 16'd2;

      vt[3].s[0] = 32'hF80007FF; vt[3].s[1] = 32'h78007800;
      vt[3].s[2] = 32'h87FF8800; vt[3].s[3] = 32'h4000C000;
      vt[3].n = 4; vt[3].last = 1'b1;
      vt[3].exp_d[0] = 32'h0077894C; vt[3].exp_d[1] = 32'hF077884C; vt[3].exp_d[2] = 32'h4C897700;
      vt[3].exp_u = 3'd4; vt[3].exp_l = 1'b1; vt[3].exp_sat = 16'd3;

      // Reset state
      repeat (3) tick();
      for (int v = 0; v < 3; v++) begin
         chk($sformatf("rst_valid%0d", v), 32'(mon_v[v]), 32'd0);
         chk($sformatf("rst_data%0d", v), mon_d[v], 32'd0);
      end
      chk("rst_user", 32'(mon_u[0]), 32'd0);
      chk("rst_last", 32'(mon_l[0]), 32'd0);
      chk("rst_sat", 32'(mon_sat[0]), 32'd0);
      chk("rst_ready", 32'(if_a.i_tready), 32'd1);
      reset = 1'b1;
      tick();

      // Table-driven vectors
      for (int t = 0; t < 4; t++) begin
         for (int j = 0; j < vt[t].n; j++) send(vt[t].s[j], vt[t].last && (j == vt[t].n - 1));
         idle();
         wait_valid();
         for (int v = 0; v < 3; v++)
            chk($sformatf("vec%0d_data%0d", t, v), mon_d[v], vt[t].exp_d[v]);
         chk($sformatf("vec%0d_user", t), 32'(mon_u[0]), 32'(vt[t].exp_u));
         chk($sformatf("vec%0d_last", t), 32'(mon_l[0]), 32'(vt[t].exp_l));
         chk($sformatf("vec%0d_sat_rnd", t), 32'(mon_sat[0]), 32'(vt[t].exp_sat));
         chk($sformatf("vec%0d_sat_lsb", t), 32'(mon_sat[2]), 32'(vt[t].exp_sat));
         chk($sformatf("vec%0d_sat_trunc", t), 32'(mon_sat[1]), 32'd0);
         tick();
      end

      // Backpressure: 8 samples offered while the sink stalls for 10 cycles
      o_tready = 1'b0;
      n_acc    = 0;
      fork
         begin
            for (int j = 0; j < 8; j++) send($urandom, 1'b0);
            idle();
         end
         begin
            repeat (10) tick();
            chk("stall_ready", 32'(if_a.i_tready), 32'd0);
            chk("stall_accepts", n_acc, 4);
            chk("stall_valid", 32'(mon_v[0]), 32'd1);
            chk("stall_qsize", exp_q[0].size(), 1);
            if (exp_q[0].size() != 0) chk("stall_data", mon_d[0], exp_q[0][0].d);
            o_tready = 1'b1;
         end
      join
      drain();
      chk("stall_total", n_acc, 8);

      // Reset with a partial word in the accumulator
      for (int j = 0; j < 3; j++) send({rnd_comp(), rnd_comp()}, 1'b0);
      idle();
      reset = 1'b0;
      #1;
      for (int v = 0; v < 3; v++) chk($sformatf("mid_rst_valid%0d", v), 32'(mon_v[v]), 32'd0);
      chk("mid_rst_data", mon_d[0], 32'd0);
      chk("mid_rst_user", 32'(mon_u[0]), 32'd0);
      chk("mid_rst_last", 32'(mon_l[0]), 32'd0);
      chk("mid_rst_sat", 32'(mon_sat[0]), 32'd0);
      pend_n  = 0;
      exp_sat = 0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      for (int j = 0; j < 4; j++) send({rnd_comp(), rnd_comp()}, 1'b0);
      idle();
      wait_valid();
      chk("post_rst_user", 32'(mon_u[0]), 32'd4);
      chk("post_rst_last", 32'(mon_l[0]), 32'd0);
      tick();

      // Random traffic with random sink stalls against the reference model
      rand_done = 0;
      fork
         begin
            for (int j = 0; j < 300; j++) begin
               send({rnd_comp(), rnd_comp()}, ($urandom_range(0, 5) == 0));
               if ($urandom_range(0, 4) == 0) begin
                  idle();
                  tick();
               end
            end
            send({rnd_comp(), rnd_comp()}, 1'b1);
            idle();
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               tick();
               o_tready = ($urandom_range(0, 3) != 0);
            end
            o_tready = 1'b1;
         end
      join
      drain();
      chk("rand_sat_rnd", 32'(mon_sat[0]), 32'(exp_sat));
      chk("rand_sat_lsb", 32'(mon_sat[2]), 32'(exp_sat));
      chk("rand_sat_trunc", 32'(mon_sat[1]), 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
